// File: rtl/operand_display_mux_if.sv
// Switch/anode inputs and decoder-facing outputs of operand_display_mux.
// The slave modport is the mux side; the master modport drives sw and anode.
interface operand_display_mux_if;
  logic [7:0] sw;
  logic [3:0] anode;
  logic [3:0] digit;
  logic       blank;
  logic       dp;
  logic       carry;
  logic       borrow;
  logic       result_valid;

  modport master (
    output sw,
    output anode,
    input  digit,
    input  blank,
    input  dp,
    input  carry,
    input  borrow,
    input  result_valid
  );

  modport slave (
    input  sw,
    input  anode,
    output digit,
    output blank,
    output dp,
    output carry,
    output borrow,
    output result_valid
  );
endinterface

// File: rtl/operand_display_mux.sv
// Debounces the operand switches, latches A/B, computes sum/diff and muxes one digit per anode.
// Optional OVERFLOW_DP_EN: drive dp low on the sum digit when carry is set and on the diff digit when borrow is set.
module operand_display_mux #(
  parameter int unsigned STABLE_CYCLES = 16
) (
  input logic                  clock,
  input logic                  reset,
  operand_display_mux_if.slave bus
);

  typedef enum logic [1:0] {StSettle, StCapture, StCompute} state_e;

  localparam logic [7:0] CntMax  = 8'(STABLE_CYCLES);
  localparam logic [7:0] CntLast = 8'(STABLE_CYCLES - 1);

  state_e     state_q, state_d;
  logic [7:0] count_q, count_d;
  logic [7:0] sw_q, sw_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [3:0] sum_q, sum_d;
  logic [3:0] diff_q, diff_d;
  logic       carry_q, carry_d;
  logic       borrow_q, borrow_d;
  logic       valid_q, valid_d;
  logic [3:0] digit_q, digit_d;
  logic       blank_q, blank_d;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    sw_d     = bus.sw;
    a_d      = a_q;
    b_d      = b_q;
    sum_d    = sum_q;
    diff_d   = diff_q;
    carry_d  = carry_q;
    borrow_d = borrow_q;
    valid_d  = 1'b0;

    unique case (state_q)
      StSettle: begin
        if (bus.sw != sw_q) begin
          count_d = 8'd0;
        end else begin
          if (count_q < CntMax) count_d = count_q + 8'd1;
          if (count_q == CntLast) state_d = StCapture;
        end
      end
      StCapture: begin
        // sw_q still holds the value that completed the stable run.
        a_d     = sw_q[3:0];
        b_d     = sw_q[7:4];
        state_d = StCompute;
      end
      StCompute: begin
        {carry_d, sum_d} = {1'b0, a_q} + {1'b0, b_q};
        diff_d           = a_q - b_q;
        borrow_d         = (a_q < b_q);
        valid_d          = 1'b1;
        count_d          = 8'd0;
        state_d          = StSettle;
      end
      default: state_d = StSettle;
    endcase
  end

  always_comb begin
    digit_d = 4'd0;
    blank_d = 1'b0;
    case (bus.anode)
      4'b0111: digit_d = a_q;
      4'b1011: digit_d = b_q;
      4'b1101: digit_d = sum_q;
      4'b1110: digit_d = diff_q;
      default: blank_d = 1'b1;
    endcase
  end

`ifdef OVERFLOW_DP_EN
  logic dp_q, dp_d;

  always_comb begin
    dp_d = 1'b1;
    if (bus.anode == 4'b1101 && carry_q)  dp_d = 1'b0;
    if (bus.anode == 4'b1110 && borrow_q) dp_d = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (!reset) dp_q <= 1'b1;
    else        dp_q <= dp_d;
  end

  assign bus.dp = dp_q;
`else
  assign bus.dp = 1'b1;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= StSettle;
      count_q  <= 8'd0;
      sw_q     <= 8'd0;
      a_q      <= 4'd0;
      b_q      <= 4'd0;
      sum_q    <= 4'd0;
      diff_q   <= 4'd0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      valid_q  <= 1'b0;
      digit_q  <= 4'd0;
      blank_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      sw_q     <= sw_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sum_q    <= sum_d;
      diff_q   <= diff_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
      valid_q  <= valid_d;
      digit_q  <= digit_d;
      blank_q  <= blank_d;
    end
  end

  assign bus.digit        = digit_q;
  assign bus.blank        = blank_q;
  assign bus.carry        = carry_q;
  assign bus.borrow       = borrow_q;
  assign bus.result_valid = valid_q;

endmodule
